alu_8bit: RTL and testbench

Registered 8-bit arithmetic/logic unit with a 3-bit opcode. It performs one of eight add, subtract, bitwise or shift operations on two 8-bit operands per accepted request. It returns the 8-bit result plus carry, zero, negative and overflow flags one clock later. It sits in the datapath as a single-cycle execution stage fed by operand/opcode registers.

---
 rtl/alu_8bit.sv | 169 ++++++++++++++++
 tb/tb_alu_8bit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit
// Registered 8-bit ALU: add, subtract, bitwise and logical shift operations
// selected by a 3-bit opcode. Operands are captured on an edge with in_valid
// high, and the result plus carry/zero/negative/overflow flags are presented
// from registers one cycle later. There is no combinational input-to-output
// path.
// ---------------------------------------------------------------------------
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] ctrl,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic       negative,
    output logic       overflow,
    output logic       out_valid
);

    // Opcode encoding
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Raw operation outcome before the zero/negative flags are derived
    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
    } op_out_t;

    // Addition: carry is bit 8 of the 9-bit sum; signed overflow when both
    // operands share a sign and the result sign differs.
    function automatic op_out_t f_add(input logic [7:0] x, input logic [7:0] y);
        op_out_t    o;
        logic [8:0] sum;
        sum   = {1'b0, x} + {1'b0, y};
        o.res = sum[7:0];
        o.c   = sum[8];
        o.v   = (x[7] == y[7]) && (sum[7] != x[7]);
        return o;
    endfunction

    // Subtraction: carry reports a borrow (x < y unsigned); signed overflow
    // when operand signs differ and the result sign differs from x.
    function automatic op_out_t f_sub(input logic [7:0] x, input logic [7:0] y);
        op_out_t    o;
        logic [8:0] diff;
        diff  = {1'b0, x} - {1'b0, y};
        o.res = diff[7:0];
        o.c   = diff[8];
        o.v   = (x[7] != y[7]) && (diff[7] != x[7]);
        return o;
    endfunction

    // Logical left shift: the ninth bit of the widened shift is the last bit
    // shifted out, which is naturally 0 for a zero shift amount.
    function automatic op_out_t f_shl(input logic [7:0] x, input logic [2:0] n);
        op_out_t    o;
        logic [8:0] wide;
        wide  = {1'b0, x} << n;
        o.res = wide[7:0];
        o.c   = wide[8];
        o.v   = 1'b0;
        return o;
    endfunction

    // Logical right shift: an extra guard bit below the LSB catches the last
    // bit shifted out, again 0 for a zero shift amount.
    function automatic op_out_t f_shr(input logic [7:0] x, input logic [2:0] n);
        op_out_t    o;
        logic [8:0] wide;
        wide  = {x, 1'b0} >> n;
        o.res = wide[8:1];
        o.c   = wide[0];
        o.v   = 1'b0;
        return o;
    endfunction

    // Bitwise results carry no carry or overflow information
    function automatic op_out_t f_logic(input logic [7:0] r);
        op_out_t o;
        o.res = r;
        o.c   = 1'b0;
        o.v   = 1'b0;
        return o;
    endfunction

    op_out_t    op_s;

    logic [7:0] result_q,   result_d;
    logic       carry_q,    carry_d;
    logic       zero_q,     zero_d;
    logic       negative_q, negative_d;
    logic       overflow_q, overflow_d;
    logic       valid_q,    valid_d;

    // Select the operation outcome for the presented opcode
    always_comb begin
        op_s = f_logic(8'h00);
        case (ctrl)
            OP_ADD:  op_s = f_add(a, b);
            OP_SUB:  op_s = f_sub(a, b);
            OP_AND:  op_s = f_logic(a & b);
            OP_OR:   op_s = f_logic(a | b);
            OP_XOR:  op_s = f_logic(a ^ b);
            OP_NOT:  op_s = f_logic(~a);
            OP_SHL:  op_s = f_shl(a, b[2:0]);
            OP_SHR:  op_s = f_shr(a, b[2:0]);
            default: op_s = f_logic(8'h00);
        endcase
    end

    // Next-state: load a new result on a request, otherwise hold and drop valid
    always_comb begin
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (in_valid) begin
            result_d   = op_s.res;
            carry_d    = op_s.c;
            zero_d     = (op_s.res == 8'h00);
            negative_d = op_s.res[7];
            overflow_d = op_s.v;
            valid_d    = 1'b1;
        end else begin
            valid_d    = 1'b0;
        end
    end

    // Output registers with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q   <= 8'h00;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_8bit.sv
// ---------------------------------------------------------------------------
// tb_alu_8bit
// Self-checking bench: directed vector table, randomized traffic against an
// arithmetic reference model, and hand-written reset/hold sequences.
// ---------------------------------------------------------------------------
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ctrl;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       out_valid;

    int checks;
    int errors;

    alu_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle: {out_valid, result, carry, zero, negative, overflow}
    typedef struct packed {
        logic       vld;
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    // Reference model built from the arithmetic definition of each opcode
    function automatic exp_t model(input int ai, input int bi, input int op);
        exp_t e;
        int   res;
        int   cy;
        int   ov;
        int   sa;
        int   sb;
        int   sh;
        sa = (ai >= 128) ? ai - 256 : ai;
        sb = (bi >= 128) ? bi - 256 : bi;
        sh = bi % 8;
        cy = 0;
        ov = 0;
        case (op)
            0: begin
                res = (ai + bi) % 256;
                cy  = (ai + bi > 255) ? 1 : 0;
                ov  = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
            end
            1: begin
                res = (ai - bi + 256) % 256;
                cy  = (ai < bi) ? 1 : 0;
                ov  = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
            end
            2: res = ai & bi;
            3: res = ai | bi;
            4: res = ai ^ bi;
            5: res = 255 - ai;
            6: begin
                res = (ai * (2 ** sh)) % 256;
                cy  = (sh != 0) ? (ai / (2 ** (8 - sh))) % 2 : 0;
            end
            default: begin
                res = ai / (2 ** sh);
                cy  = (sh != 0) ? (ai / (2 ** (sh - 1))) % 2 : 0;
            end
        endcase
        e.vld = 1'b1;
        e.r   = res[7:0];
        e.c   = cy[0];
        e.z   = (res == 0);
        e.n   = (res >= 128);
        e.v   = ov[0];
        return e;
    endfunction

    task automatic check(input string name, input exp_t exp);
        exp_t act;
        act = '{vld: out_valid, r: result, c: carry, z: zero, n: negative, v: overflow};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got vld=%0b r=%02h c=%0b z=%0b n=%0b v=%0b, want vld=%0b r=%02h c=%0b z=%0b n=%0b v=%0b",
                     name, act.vld, act.r, act.c, act.z, act.n, act.v,
                     exp.vld, exp.r, exp.c, exp.z, exp.n, exp.v);
        end
    endtask

    // Drive inputs at the falling edge, then wait past the next rising edge
    task automatic drive(input logic rn, input logic iv, input logic [7:0] ai,
                         input logic [7:0] bi, input logic [2:0] op);
        @(negedge clk);
        rst_n    = rn;
        in_valid = iv;
        a        = ai;
        b        = bi;
        ctrl     = op;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    exp_t held;
    exp_t e;
    exp_t zero_exp;

    initial begin
        checks   = 0;
        errors   = 0;
        zero_exp = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        ctrl     = 3'b000;

        // Directed table: opcode sweep, arithmetic flags, shift edges
        vecs.push_back('{8'd24,  8'd20,  3'd0, 8'd44,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd1, 8'd4,   1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd2, 8'd16,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd3, 8'd28,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd4, 8'd12,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd5, 8'd231, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd6, 8'd128, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'd24,  8'd20,  3'd7, 8'd1,   1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd200, 8'd100, 3'd0, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'd127, 8'd1,   3'd0, 8'd128, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'd20,  8'd24,  3'd1, 8'd252, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'd128, 8'd1,   3'd1, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'd5,   8'd5,   3'd1, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h81,  8'h00,  3'd6, 8'h81,  1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h81,  8'h01,  3'd6, 8'h02,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h81,  8'h07,  3'd7, 8'h01,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h81,  8'h09,  3'd6, 8'h02,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h81,  8'h01,  3'd7, 8'h40,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hFF,  8'h5A,  3'd5, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h81,  8'h00,  3'd7, 8'h81,  1'b0, 1'b0, 1'b1, 1'b0});

        // Reset held for two cycles with a live request presented
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 3'd0);
        check("reset_c1", zero_exp);
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 3'd0);
        check("reset_c2", zero_exp);

        // Release with no request, then the first request one cycle later
        drive(1'b1, 1'b0, 8'h00, 8'h00, 3'd0);
        check("post_reset_idle", zero_exp);
        drive(1'b1, 1'b1, 8'd1, 8'd1, 3'd0);
        check("first_request", '{1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0});

        // Table vectors applied back-to-back
        foreach (vecs[i]) begin
            drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("vec%0d", i),
                  '{1'b1, vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v});
        end

        // Hold: ADD 1+2 then three idle cycles with toggling inputs
        drive(1'b1, 1'b1, 8'd1, 8'd2, 3'd0);
        check("hold_load", '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
            check($sformatf("hold_idle%0d", k), '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        end

        // Reset arriving together with a request discards it
        drive(1'b1, 1'b1, 8'd200, 8'd100, 3'd0);
        check("pre_midreset", '{1'b1, 8'd44, 1'b1, 1'b0, 1'b0, 1'b0});
        drive(1'b0, 1'b1, 8'hF0, 8'h0F, 3'd4);
        check("midstream_reset", zero_exp);
        drive(1'b1, 1'b1, 8'hF0, 8'h0F, 3'd4);
        check("after_midreset", '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});

        // Randomized traffic with sparse valid against the reference model
        held = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 300; k++) begin
            logic       iv;
            logic [7:0] ra;
            logic [7:0] rb;
            logic [2:0] rop;
            iv  = ($urandom_range(0, 3) != 0);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom);
            drive(1'b1, iv, ra, rb, rop);
            if (iv) begin
                held = model(int'(ra), int'(rb), int'(rop));
            end else begin
                held.vld = 1'b0;
            end
            e = held;
            check($sformatf("rand%0d", k), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
